fec_fabric_rx_checker: RTL and testbench

//  Receiving end of the 16-bit pipelined WB fabric used by the FEC encoder/decoder source ports.

---
 rtl/fec_fabric_rx_checker.sv | 187 ++++++++++++++++++
 tb/tb_fec_fabric_rx_checker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fec_fabric_rx_checker.sv
// fec_fabric_rx_checker
//   Sink for the 16-bit pipelined WB fabric. It checks the destination MAC
//   against dmac_i and measures the frame size in bytes. It keeps saturating
//   counters of received, dropped and errored frames.
//   Optional build macro FEC_RX_CHECKER_RAND_STALL_EN adds LFSR-driven
//   random stall outside IDLE.
module fec_fabric_rx_checker #(
   parameter int g_cnt_width  = 32,
   parameter int g_size_width = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    snk_cyc_i,
   input  logic                    snk_stb_i,
   input  logic                    snk_we_i,
   input  logic [1:0]              snk_sel_i,
   input  logic [1:0]              snk_adr_i,
   input  logic [15:0]             snk_dat_i,
   output logic                    snk_stall_o,
   output logic                    snk_ack_o,
   input  logic [47:0]             dmac_i,
   input  logic                    clr_i,
   output logic [g_cnt_width-1:0]  rcv_cnt_o,
   output logic [g_cnt_width-1:0]  drp_cnt_o,
   output logic [g_cnt_width-1:0]  err_cnt_o,
   output logic [g_size_width-1:0] last_size_o,
   output logic                    frame_done_o,
   output logic                    frame_ok_o
);

   localparam int SZW = g_size_width + 1;
   localparam logic [g_cnt_width-1:0] CNT_ONE = {{(g_cnt_width-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DONE} state_t;

   state_t                  state_q, state_nxt;
   logic                    armed_q;
   logic                    ack_q;
   logic [1:0]              hdr_cnt_q, hdr_cnt_nxt, cnt_base;
   logic                    mis_q, mis_nxt, mis_base;
   logic                    err_q, err_nxt, err_base;
   logic [g_size_width-1:0] size_q, size_nxt, size_base;
   logic [SZW-1:0]          size_inc, size_sum;
   logic [15:0]             mac_word;
   logic [g_size_width-1:0] last_size_q;
   logic [g_cnt_width-1:0]  rcv_q, drp_q, errc_q;
   logic                    stall, accept, start, in_frame, frame_bad, rnd_stall;
   logic                    unused_we;

   assign unused_we = snk_we_i;

`ifdef FEC_RX_CHECKER_RAND_STALL_EN
   logic [15:0] lfsr_q;

   // x^16+x^14+x^13+x^11+1 Fibonacci LFSR, free-running
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) lfsr_q <= 16'hACE1;
      else          lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign rnd_stall = (lfsr_q[1:0] == 2'b00);
`else
   assign rnd_stall = 1'b0;
`endif

   // A new frame starts only on a cyc that was seen low first, so a frame
   // still in progress across a reset is ignored until cyc drops.
   assign start    = (state_q == S_IDLE) && snk_cyc_i && armed_q;
   assign in_frame = start || (state_q == S_HDR) || (state_q == S_PAYLOAD);
   assign accept   = snk_cyc_i && snk_stb_i && !stall;

   // Stall decode: always in DONE, optionally random in HDR/PAYLOAD
   always_comb begin
      stall = 1'b0;
      case (state_q)
         S_HDR, S_PAYLOAD: stall = rnd_stall;
         S_DONE:           stall = 1'b1;
         default:          stall = 1'b0;
      endcase
   end

   // Per-frame accumulation; a starting frame is accumulated from zero
   always_comb begin
      cnt_base  = hdr_cnt_q;
      mis_base  = mis_q;
      err_base  = err_q;
      size_base = size_q;
      if (start) begin
         cnt_base  = '0;
         mis_base  = 1'b0;
         err_base  = 1'b0;
         size_base = '0;
      end
      hdr_cnt_nxt = cnt_base;
      mis_nxt     = mis_base;
      err_nxt     = err_base;
      size_nxt    = size_base;
      size_inc    = (snk_sel_i == 2'b10) ? SZW'(1) : SZW'(2);
      size_sum    = {1'b0, size_base} + size_inc;
      case (cnt_base)
         2'd0:    mac_word = dmac_i[47:32];
         2'd1:    mac_word = dmac_i[31:16];
         default: mac_word = dmac_i[15:0];
      endcase
      if (in_frame && accept) begin
         case (snk_adr_i)
            2'b00: begin
               if (cnt_base != 2'd3) begin
                  hdr_cnt_nxt = cnt_base + 2'd1;
                  if (snk_dat_i != mac_word) mis_nxt = 1'b1;
               end
               size_nxt = size_sum[g_size_width] ? '1 : size_sum[g_size_width-1:0];
            end
            2'b10:   if (snk_dat_i[1]) err_nxt = 1'b1;
            default: ;
         endcase
      end
   end

   // FSM next state
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:    if (start) state_nxt = S_HDR;
         S_HDR: begin
            if (!snk_cyc_i)               state_nxt = S_DONE;
            else if (hdr_cnt_nxt == 2'd3) state_nxt = S_PAYLOAD;
         end
         S_PAYLOAD: if (!snk_cyc_i) state_nxt = S_DONE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // FSM state, frame accumulators, start arming, ack and captured size
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         armed_q     <= 1'b0;
         ack_q       <= 1'b0;
         hdr_cnt_q   <= '0;
         mis_q       <= 1'b0;
         err_q       <= 1'b0;
         size_q      <= '0;
         last_size_q <= '0;
      end else begin
         state_q   <= state_nxt;
         ack_q     <= accept;
         hdr_cnt_q <= hdr_cnt_nxt;
         mis_q     <= mis_nxt;
         err_q     <= err_nxt;
         size_q    <= size_nxt;
         if (!snk_cyc_i)  armed_q <= 1'b1;
         else if (start)  armed_q <= 1'b0;
         if (state_nxt == S_DONE && state_q != S_DONE) last_size_q <= size_q;
      end
   end

   assign frame_bad = err_q || (hdr_cnt_q != 2'd3);

   // Saturating frame counters, bumped while in DONE; clear has priority
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clr_i) begin
         rcv_q  <= '0;
         drp_q  <= '0;
         errc_q <= '0;
      end else if (state_q == S_DONE) begin
         if (frame_bad) begin
            if (errc_q != '1) errc_q <= errc_q + CNT_ONE;
         end else if (mis_q) begin
            if (drp_q != '1) drp_q <= drp_q + CNT_ONE;
         end else begin
            if (rcv_q != '1) rcv_q <= rcv_q + CNT_ONE;
         end
      end
   end

   assign snk_stall_o  = stall;
   assign snk_ack_o    = ack_q;
   assign rcv_cnt_o    = rcv_q;
   assign drp_cnt_o    = drp_q;
   assign err_cnt_o    = errc_q;
   assign last_size_o  = last_size_q;
   assign frame_done_o = (state_q == S_DONE);
   assign frame_ok_o   = (state_q == S_DONE) && !frame_bad && !mis_q;

endmodule

// File: tb/tb_fec_fabric_rx_checker.sv
// tb_fec_fabric_rx_checker
//   Directed plus randomized frames. Expected results come from a frame-level
//   model (byte count, header MAC, status flag) and a cycle monitor that
//   checks ack, counters and frame_done reports.
module tb_fec_fabric_rx_checker;

   localparam logic [47:0] MAC_A = 48'h112233445566;

   typedef struct { logic [1:0] adr; logic [15:0] dat; logic [1:0] sel; } word_t;
   typedef struct { int cls; int size; } exp_t;   // cls: 0 rcv, 1 drp, 2 err

   logic        clk_i;
   logic        rst_n_i;
   logic        snk_cyc_i, snk_stb_i, snk_we_i;
   logic [1:0]  snk_sel_i, snk_adr_i;
   logic [15:0] snk_dat_i;
   logic        snk_stall_o, snk_ack_o;
   logic [47:0] dmac_i;
   logic        clr_i;
   logic [31:0] rcv_cnt_o, drp_cnt_o, err_cnt_o;
   logic [15:0] last_size_o;
   logic        frame_done_o, frame_ok_o;

   word_t fq[$];
   exp_t  exp_q[$];
   exp_t  mon_e;
   int    mon_cls;
   int    n_assert = 0, n_fail = 0;
   int    exp_rcv = 0, exp_drp = 0, exp_err = 0;
   int    n_acc = 0, n_ack = 0, n_sent = 0, n_rstall = 0;
   int    acc0, ack0, sent0;
   logic  ack_exp = 1'b0;
   bit    mon_en = 1'b0;

   fec_fabric_rx_checker #(.g_cnt_width(32), .g_size_width(16)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .snk_cyc_i(snk_cyc_i), .snk_stb_i(snk_stb_i), .snk_we_i(snk_we_i),
      .snk_sel_i(snk_sel_i), .snk_adr_i(snk_adr_i), .snk_dat_i(snk_dat_i),
      .snk_stall_o(snk_stall_o), .snk_ack_o(snk_ack_o),
      .dmac_i(dmac_i), .clr_i(clr_i),
      .rcv_cnt_o(rcv_cnt_o), .drp_cnt_o(drp_cnt_o), .err_cnt_o(err_cnt_o),
      .last_size_o(last_size_o), .frame_done_o(frame_done_o), .frame_ok_o(frame_ok_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Frame-level reference: bytes from data words, MAC from the first three
   // data words, error from a flagged status word or a short header.
   function automatic exp_t model(input word_t q[$], input logic [47:0] mac);
      exp_t e;
      int   nd = 0;
      bit   err = 0, mis = 0;
      e.size = 0;
      foreach (q[i]) begin
         if (q[i].adr == 2'b00) begin
            if (nd < 3 && q[i].dat != 16'(mac >> (32 - 16 * nd))) mis = 1;
            nd++;
            e.size += (q[i].sel == 2'b10) ? 1 : 2;
         end else if (q[i].adr == 2'b10 && q[i].dat[1]) begin
            err = 1;
         end
      end
      if (e.size > 65535) e.size = 65535;
      e.cls = (err || nd < 3) ? 2 : (mis ? 1 : 0);
      return e;
   endfunction

   // stat: 0 none, 1 benign status word, 2 status word with error bit
   task automatic build(input int nbytes, input logic [47:0] dst, input int oob_pct, input int stat);
      byte unsigned b[];
      word_t w;
      b = new[nbytes];
      for (int i = 0; i < nbytes; i++) b[i] = (i < 6) ? dst[47 - 8 * i -: 8] : 8'($urandom);
      fq.delete();
      for (int i = 0; i < nbytes; i += 2) begin
         if (int'($urandom_range(99)) < oob_pct) begin
            w.adr = ($urandom_range(1) == 1) ? 2'b01 : 2'b11;
            w.dat = 16'($urandom);
            w.sel = 2'b11;
            fq.push_back(w);
         end
         w.adr = 2'b00;
         if (i + 1 < nbytes) begin w.dat = {b[i], b[i + 1]}; w.sel = 2'b11; end
         else                begin w.dat = {b[i], 8'h00};    w.sel = 2'b10; end
         fq.push_back(w);
      end
      if (stat != 0) begin
         w.adr = 2'b10;
         w.dat = (stat == 2) ? 16'h0002 : 16'h0001;
         w.sel = 2'b11;
         fq.insert($urandom_range(fq.size()), w);
      end
   endtask

   task automatic put_word(input word_t w);
      bit acc;
      snk_stb_i = 1'b1; snk_adr_i = w.adr; snk_dat_i = w.dat; snk_sel_i = w.sel;
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
         @(negedge clk_i);
         acc = (snk_stall_o === 1'b0);
         @(posedge clk_i); #1;
      end
      chk("word_accepted", acc, 1'b1);
      if (acc) n_sent++;
   endtask

   // Sends fq as one frame; returns one cycle after the last accept with cyc low
   task automatic send(input logic [47:0] mac);
      exp_q.push_back(model(fq, mac));
      @(posedge clk_i); #1;
      snk_cyc_i = 1'b1;
      foreach (fq[i]) put_word(fq[i]);
      snk_stb_i = 1'b0;
      snk_cyc_i = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk_i);
      chk("frame_done_seen", exp_q.size(), 0);
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_clr();
      clr_i = 1'b1;
      @(posedge clk_i); #1;
      clr_i = 1'b0;
   endtask

   // Cycle monitor: ack one cycle after each accept, counters, done reports
   always @(negedge clk_i) begin
      if (mon_en) begin
         mon_cls = -1;
         chk("ack", snk_ack_o, ack_exp);
         chk("rcv_cnt", rcv_cnt_o, exp_rcv);
         chk("drp_cnt", drp_cnt_o, exp_drp);
         chk("err_cnt", err_cnt_o, exp_err);
`ifndef FEC_RX_CHECKER_RAND_STALL_EN
         chk("stall_only_in_done", snk_stall_o, frame_done_o === 1'b1);
`else
         if (snk_stall_o === 1'b1 && frame_done_o !== 1'b1) n_rstall++;
`endif
         if (frame_done_o !== 1'b0) begin
            chk("frame_done_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               mon_e   = exp_q.pop_front();
               mon_cls = mon_e.cls;
               chk("frame_ok", frame_ok_o, mon_e.cls == 0);
               chk("last_size", last_size_o, mon_e.size);
            end
         end else begin
            chk("frame_ok_outside_done", frame_ok_o, 1'b0);
         end
         ack_exp = rst_n_i && snk_cyc_i && snk_stb_i && (snk_stall_o === 1'b0);
         if (ack_exp) n_acc++;
         if (snk_ack_o === 1'b1) n_ack++;
         if (!rst_n_i || clr_i) begin
            exp_rcv = 0; exp_drp = 0; exp_err = 0;
         end else if (mon_cls == 0) exp_rcv++;
         else if (mon_cls == 1)     exp_drp++;
         else if (mon_cls == 2)     exp_err++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_i = 1'b0; snk_cyc_i = 1'b0; snk_stb_i = 1'b0; snk_we_i = 1'b1;
      snk_sel_i = 2'b11; snk_adr_i = 2'b00; snk_dat_i = '0;
      clr_i = 1'b0; dmac_i = MAC_A;
      repeat (3) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      chk("rst_stall", snk_stall_o, 1'b0);
      chk("rst_ack", snk_ack_o, 1'b0);
      chk("rst_rcv", rcv_cnt_o, 0);
      chk("rst_drp", drp_cnt_o, 0);
      chk("rst_err", err_cnt_o, 0);
      chk("rst_size", last_size_o, 0);
      chk("rst_done", frame_done_o, 1'b0);
      chk("rst_ok", frame_ok_o, 1'b0);
      mon_en = 1'b1;

      // 1) 1500-byte matching frame
      build(1500, MAC_A, 0, 0); send(dmac_i); drain();
      chk("t1_rcv", rcv_cnt_o, 1);
      chk("t1_size", last_size_o, 1500);

      // 2) 61-byte odd frame with foreign destination
      build(61, 48'h16212C2C3742, 0, 0); send(dmac_i); drain();
      chk("t2_drp", drp_cnt_o, 1);
      chk("t2_size", last_size_o, 61);

      // 3) flagged status word, then a 2-word runt
      build(64, MAC_A, 0, 2); send(dmac_i); drain();
      chk("t3_err1", err_cnt_o, 1);
      build(4, MAC_A, 0, 0); send(dmac_i); drain();
      chk("t3_err2", err_cnt_o, 2);

      // 4) 100 back-to-back frames, 64..163 bytes, OOB/user words mixed in
      pulse_clr();
      acc0 = n_acc; ack0 = n_ack; sent0 = n_sent;
      for (int i = 0; i < 100; i++) begin
         build(64 + i, MAC_A, 10, 0);
         send(dmac_i);
      end
      drain();
      chk("t4_rcv", rcv_cnt_o, 100);
      chk("t4_err", err_cnt_o, 0);
      chk("t4_acks_eq_accepts", n_ack - ack0, n_acc - acc0);
      chk("t4_accepts_eq_sent", n_acc - acc0, n_sent - sent0);

      // 5) clear in the frame_done cycle, then reset mid-payload
      build(64, MAC_A, 0, 0); send(dmac_i);
      @(posedge clk_i); #1;
      chk("t5_done_cycle", frame_done_o, 1'b1);
      pulse_clr();
      chk("t5_rcv_cleared", rcv_cnt_o, 0);
      chk("t5_drp_cleared", drp_cnt_o, 0);
      chk("t5_err_cleared", err_cnt_o, 0);
      build(70, MAC_A, 0, 0); send(dmac_i); drain();
      chk("t5_rcv_after_clr", rcv_cnt_o, 1);
      build(200, MAC_A, 0, 0);
      @(posedge clk_i); #1;
      snk_cyc_i = 1'b1;
      for (int i = 0; i < 20; i++) put_word(fq[i]);
      snk_stb_i = 1'b1; snk_adr_i = fq[20].adr; snk_dat_i = fq[20].dat; snk_sel_i = fq[20].sel;
      rst_n_i = 1'b0;
      @(posedge clk_i); #1;
      snk_stb_i = 1'b0; snk_cyc_i = 1'b0;
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      chk("t5_rst_ack", snk_ack_o, 1'b0);
      chk("t5_rst_rcv", rcv_cnt_o, 0);
      chk("t5_rst_size", last_size_o, 0);
      chk("t5_rst_done", frame_done_o, 1'b0);
      repeat (5) @(posedge clk_i);
      #1;
      chk("t5_no_partial_count", rcv_cnt_o + drp_cnt_o + err_cnt_o, 0);
      build(90, MAC_A, 0, 0); send(dmac_i); drain();
      chk("t5_recovered", rcv_cnt_o, 1);

      // Randomized mix of sizes, destinations, status and OOB words
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(3) == 0) dmac_i = {16'($urandom), $urandom};
         build(int'($urandom_range(200, 4)),
               ($urandom_range(3) == 0) ? {16'($urandom), $urandom} : dmac_i,
               15, int'($urandom_range(2)));
         send(dmac_i);
      end
      drain();
      chk("rand_acks_eq_accepts", n_ack, n_acc);

`ifdef FEC_RX_CHECKER_RAND_STALL_EN
      // 6) ten 1500-byte frames under random stall
      dmac_i = MAC_A;
      pulse_clr();
      for (int i = 0; i < 10; i++) begin
         build(1500, MAC_A, 0, 0);
         send(dmac_i);
      end
      drain();
      chk("t6_rcv", rcv_cnt_o, 10);
      chk("t6_stall_seen", n_rstall > 0, 1'b1);
`endif

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
